// File: rtl/core_step_ctrl.sv
// rtl/core_step_ctrl.sv - execution controller: single-step, divided free-run and PC breakpoint as a core clock-enable
module core_step_ctrl #(
    parameter int RUN_DIV        = 1_000_000,
    parameter int STEP_CNT_WIDTH = 16
) (
    input  logic                      clk_i,
    input  logic                      arstn_i,
    input  logic                      step_btn_i,
    input  logic                      run_sw_i,
    input  logic                      bp_en_i,
    input  logic [31:0]               bp_addr_i,
    input  logic [31:0]               instr_addr_i,
    output logic                      core_ce_o,
    output logic                      running_o,
    output logic                      bp_hit_o,
    output logic [STEP_CNT_WIDTH-1:0] step_cnt_o
);

    localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_STEP  = 2'd1,
        ST_RUN   = 2'd2,
        ST_BREAK = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [DIV_W-1:0]          div_q, div_d;
    logic [STEP_CNT_WIDTH-1:0] step_cnt_q, step_cnt_d;
    logic                      btn_q, btn_d;
    logic                      bp_armed_q, bp_armed_d;

    logic                      step_req;
    logic                      bp_match;
    logic                      tick;
    logic                      ce;
    logic                      running;
    logic                      bp_hit;

    // A held button produces one request; the breakpoint is ignored until the
    // first instruction of a run has retired so a run can resume from bp_addr.
    assign step_req = step_btn_i & ~btn_q;
    assign bp_match = bp_en_i & (instr_addr_i == bp_addr_i) & bp_armed_q;
    assign tick     = (div_q == DIV_LAST);

    // State and datapath registers, cleared immediately by reset
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q    <= ST_HALT;
            div_q      <= '0;
            step_cnt_q <= '0;
            btn_q      <= 1'b0;
            bp_armed_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            step_cnt_q <= step_cnt_d;
            btn_q      <= btn_d;
            bp_armed_q <= bp_armed_d;
        end
    end

    // Next-state decode; a step request outranks the run switch
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_HALT: begin
                if (step_req) begin
                    state_d = ST_STEP;
                end else if (run_sw_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_STEP: begin
                state_d = ST_HALT;
            end
            ST_RUN: begin
                if (!run_sw_i) begin
                    state_d = ST_HALT;
                end else if (bp_match) begin
                    state_d = ST_BREAK;
                end
            end
            ST_BREAK: begin
                if (step_req) begin
                    state_d = ST_STEP;
                end else if (!run_sw_i) begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    // Output decode from registered state; RUN pulses are gated by the switch and breakpoint
    always_comb begin
        ce      = 1'b0;
        running = 1'b0;
        bp_hit  = 1'b0;
        unique case (state_q)
            ST_STEP: begin
                ce = 1'b1;
            end
            ST_RUN: begin
                running = 1'b1;
                ce      = tick & run_sw_i & ~bp_match;
            end
            ST_BREAK: begin
                bp_hit = 1'b1;
            end
            default: begin
                ce = 1'b0;
            end
        endcase
    end

    // Divider, breakpoint arming, button history and retired-step counter
    always_comb begin
        btn_d      = step_btn_i;
        div_d      = div_q;
        bp_armed_d = bp_armed_q;
        step_cnt_d = ce ? (step_cnt_q + STEP_CNT_WIDTH'(1)) : step_cnt_q;
        unique case (state_q)
            ST_HALT: begin
                if (!step_req && run_sw_i) begin
                    div_d      = '0;
                    bp_armed_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (!run_sw_i) begin
                    div_d = '0;
                end else if (!bp_match) begin
                    div_d = tick ? '0 : (div_q + 1'b1);
                    if (ce) begin
                        bp_armed_d = 1'b1;
                    end
                end
            end
            default: begin
                div_d = div_q;
            end
        endcase
    end

    assign core_ce_o  = ce;
    assign running_o  = running;
    assign bp_hit_o   = bp_hit;
    assign step_cnt_o = step_cnt_q;

endmodule

// File: tb/tb_core_step_ctrl.sv
// tb/tb_core_step_ctrl.sv - scoreboard bench for core_step_ctrl
module tb_core_step_ctrl;

    localparam int RUN_DIV = 4;
    localparam int CW      = 4;

    logic          clk;
    logic          arstn;
    logic          step_btn;
    logic          run_sw;
    logic          bp_en;
    logic [31:0]   bp_addr;
    logic [31:0]   pc = 32'd0;
    logic          core_ce_o;
    logic          running_o;
    logic          bp_hit_o;
    logic [CW-1:0] step_cnt_o;

    typedef struct {
        int          cyc;
        logic [31:0] cnt;
        logic [31:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_cnt = 32'd0;
    logic [31:0] exp_pc = 32'd0;
    logic        ce_at_neg = 1'b0;
    logic        pc_wr = 1'b0;
    logic [31:0] pc_wr_val = 32'd0;
    int          n;
    int          k;

    core_step_ctrl #(
        .RUN_DIV        (RUN_DIV),
        .STEP_CNT_WIDTH (CW)
    ) dut (
        .clk_i        (clk),
        .arstn_i      (arstn),
        .step_btn_i   (step_btn),
        .run_sw_i     (run_sw),
        .bp_en_i      (bp_en),
        .bp_addr_i    (bp_addr),
        .instr_addr_i (pc),
        .core_ce_o    (core_ce_o),
        .running_o    (running_o),
        .bp_hit_o     (bp_hit_o),
        .step_cnt_o   (step_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Core PC model: advances by 4 on each enable pulse, wrapping inside 0x00..0x1F
    always @(posedge clk) begin
        if (pc_wr) begin
            pc <= pc_wr_val;
        end else if (ce_at_neg) begin
            pc <= (pc + 32'd4) & 32'h1F;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every enable pulse must match the oldest expected pulse
    always @(negedge clk) begin
        ce_at_neg = arstn && core_ce_o;
        if (ce_at_neg) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: core_ce_o=1 at cycle %0d, expected no pulse", cyc);
            end else begin
                e = exp_q.pop_front();
                check("pulse_cycle", 32'(cyc), 32'(e.cyc));
                check("pulse_step_cnt", 32'(step_cnt_o), e.cnt);
                check("pulse_pc", pc, e.pc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int c);
        exp_t x;
        x.cyc   = c;
        x.cnt   = exp_cnt;
        x.pc    = exp_pc;
        exp_q.push_back(x);
        exp_cnt = (exp_cnt + 32'd1) & 32'((1 << CW) - 1);
        exp_pc  = (exp_pc + 32'd4) & 32'h1F;
    endtask

    task automatic set_pc(input logic [31:0] v);
        pc_wr_val = v;
        pc_wr     = 1'b1;
        tick();
        pc_wr     = 1'b0;
        exp_pc    = v;
    endtask

    task automatic press();
        n = cyc;
        step_btn = 1'b1;
        push(n + 1);
        repeat (5) tick();
        step_btn = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        arstn    = 1'b0;
        step_btn = 1'b0;
        run_sw   = 1'b0;
        bp_en    = 1'b0;
        bp_addr  = 32'd0;
        repeat (2) tick();
        check("reset_ce", 32'(core_ce_o), 32'd0);
        check("reset_running", 32'(running_o), 32'd0);
        check("reset_bp_hit", 32'(bp_hit_o), 32'd0);
        check("reset_step_cnt", 32'(step_cnt_o), 32'd0);
        arstn = 1'b1;
        repeat (2) tick();

        // Held button gives one pulse per press
        for (int i = 0; i < 3; i++) press();
        check("step_cnt_after_3_presses", 32'(step_cnt_o), 32'd3);

        // Free run at RUN_DIV=4, then drop the switch
        n = cyc;
        run_sw = 1'b1;
        for (int i = 0; i < 4; i++) push(n + 4 + 4 * i);
        repeat (2) tick();
        check("run_running", 32'(running_o), 32'd1);
        repeat (18) tick();
        run_sw = 1'b0;
        check("run_running_at_drop", 32'(running_o), 32'd1);
        tick();
        check("run_running_after_drop", 32'(running_o), 32'd0);
        repeat (4) tick();
        check("step_cnt_after_run", 32'(step_cnt_o), 32'd7);

        // Asynchronous reset in RUN with divider at 2
        n = cyc;
        run_sw = 1'b1;
        repeat (3) tick();
        check("pre_reset_running", 32'(running_o), 32'd1);
        #2 arstn = 1'b0;
        #1;
        check("async_reset_ce", 32'(core_ce_o), 32'd0);
        check("async_reset_running", 32'(running_o), 32'd0);
        check("async_reset_bp_hit", 32'(bp_hit_o), 32'd0);
        check("async_reset_step_cnt", 32'(step_cnt_o), 32'd0);
        run_sw = 1'b0;
        tick();
        arstn   = 1'b1;
        exp_cnt = 32'd0;
        tick();
        check("post_reset_running", 32'(running_o), 32'd0);
        check("post_reset_bp_hit", 32'(bp_hit_o), 32'd0);
        repeat (3) tick();
        set_pc(32'h0);

        // Breakpoint at 0x10 from PC 0, then single step out of BREAK
        bp_en   = 1'b1;
        bp_addr = 32'h10;
        n = cyc;
        run_sw = 1'b1;
        for (int i = 0; i < 4; i++) push(n + 4 + 4 * i);
        repeat (18) tick();
        check("bp_hit_set", 32'(bp_hit_o), 32'd1);
        check("bp_running_clear", 32'(running_o), 32'd0);
        check("bp_step_cnt", 32'(step_cnt_o), 32'd4);
        repeat (3) tick();
        k = cyc;
        step_btn = 1'b1;
        run_sw   = 1'b0;
        push(k + 1);
        tick();
        check("bp_step_hit_clear", 32'(bp_hit_o), 32'd0);
        tick();
        check("bp_step_pc", pc, 32'h14);
        check("bp_step_cnt_after", 32'(step_cnt_o), 32'd5);
        step_btn = 1'b0;
        repeat (2) tick();

        // Resume from PC equal to the breakpoint, break again after wrapping
        set_pc(32'h10);
        n = cyc;
        run_sw = 1'b1;
        for (int i = 0; i < 8; i++) push(n + 4 + 4 * i);
        repeat (10) tick();
        check("resume_running", 32'(running_o), 32'd1);
        repeat (24) tick();
        check("resume_bp_hit", 32'(bp_hit_o), 32'd1);
        run_sw = 1'b0;
        tick();
        check("break_to_halt_hit", 32'(bp_hit_o), 32'd0);
        check("break_to_halt_running", 32'(running_o), 32'd0);
        repeat (2) tick();

        // Step and run together from HALT, counter wraps 15 -> 0
        bp_en = 1'b0;
        n = cyc;
        step_btn = 1'b1;
        run_sw   = 1'b1;
        push(n + 1);
        push(n + 6);
        push(n + 10);
        tick();
        check("combo_step_not_running", 32'(running_o), 32'd0);
        tick();
        check("combo_halt_not_running", 32'(running_o), 32'd0);
        tick();
        check("combo_running", 32'(running_o), 32'd1);
        step_btn = 1'b0;
        repeat (8) tick();
        check("wrap_step_cnt", 32'(step_cnt_o), 32'd0);
        run_sw = 1'b0;
        tick();
        check("wrap_running_clear", 32'(running_o), 32'd0);
        repeat (5) tick();

        check("pending_pulses", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
